// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among 8 requesters; registered one-hot grant.
// Grant appears one edge after the request. A release always leaves a one-cycle idle bubble.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_gnt;
  logic [2:0]    r_id;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_to;

  logic [7:0]    w_gnt_nxt;
  logic [2:0]    w_id_nxt;
  logic [2:0]    w_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_to_nxt;

  logic [2:0]    w_scan;
  logic [2:0]    w_win;
  logic          w_any;
  logic          w_own_req;
  logic          w_t;
  logic          w_rel;

  // Descending scan so the lowest offset from r_ptr is written last and wins.
  always_comb begin
    w_win  = '0;
    w_scan = '0;
    for (int k = 7; k >= 0; k--) begin
      w_scan = r_ptr + 3'(k);
      if (req[w_scan]) w_win = w_scan;
    end
  end

  assign w_any     = |req;
  assign w_own_req = req[r_id];
  assign w_t       = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);
  assign w_rel     = rel | ~w_own_req | w_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_id    <= w_id_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_to    <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
      S_GRANT: if (w_rel) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt = r_gnt;
    w_id_nxt  = r_id;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_to_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        w_id_nxt  = '0;
        if (w_any) begin
          w_gnt_nxt = 8'b1 << w_win;
          w_id_nxt  = w_win;
          w_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_gnt_nxt = '0;
          w_id_nxt  = '0;
          w_ptr_nxt = r_id + 3'd1;
          // An explicit release or a dropped request on the limit cycle is not a timeout.
          w_to_nxt  = w_t & ~rel & w_own_req;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_gnt_nxt = '0;
        w_id_nxt  = '0;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_id;
  assign busy    = (r_state == S_GRANT);
  assign timeout = r_to;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_busy:   assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8 (MAX_HOLD=4): vector table, directed corner sequences,
// and random traffic against a queue-free owner/pointer reference model.
module tb_rr_arbiter_8;
  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_errors;

  // Reference model: owner index (-1 = nobody), rotating pointer, hold count.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_to;

  typedef struct {
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[19];

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] eg, input logic [2:0] ei,
                           input logic eb, input logic et);
    check({name, ".gnt"}, 32'(gnt), 32'(eg));
    check({name, ".gnt_id"}, 32'(gnt_id), 32'(ei));
    check({name, ".busy"}, 32'(busy), 32'(eb));
    check({name, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  // Inputs change 1ns after an edge; outputs are sampled at the same point.
  task automatic step(input logic [7:0] r, input logic l);
    req = r;
    rel = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] r);
    rst_n = 1'b0;
    req   = r;
    rel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_to    = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic l);
    bit found;
    bit t;
    if (m_owner < 0) begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found   = 1;
          m_owner = (m_ptr + k) % 8;
          m_cnt   = 0;
        end
      end
    end else begin
      t = (m_cnt == MH - 1);
      if (l || !r[m_owner] || t) begin
        m_to    = (t && !l && r[m_owner]) ? 1 : 0;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_cnt++;
        m_to = 0;
      end
    end
  endtask

  initial begin
    logic [7:0] cur_req;
    logic       cur_rel;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req      = '0;
    rel      = 1'b0;

    tbl[0]  = '{8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
    tbl[3]  = '{8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
    tbl[4]  = '{8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    tbl[6]  = '{8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[8]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[11] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[12] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[13] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[14] = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
    tbl[15] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[16] = '{8'hFF, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[17] = '{8'hEF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[18] = '{8'hEF, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};

    // Reset values with every requester asserting, then the vector table.
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].req, tbl[i].rel);
      check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].to);
    end

    // Full rotation with a one-cycle bubble between owners.
    do_reset(8'hFF);
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0);
      check_out($sformatf("rot%0d.grant", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      step(8'hFF, 1'b0);
      check_out($sformatf("rot%0d.hold", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      step(8'hFF, 1'b1);
      check_out($sformatf("rot%0d.bubble", k), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Async reset mid-grant clears outputs without a clock edge.
    step(8'hFF, 1'b0);
    check("async.pre_gnt", 32'(gnt), 32'h02);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Owner 2 drops req and releases on the hold-limit cycle: one release, no timeout.
    do_reset(8'h00);
    step(8'h04, 1'b0);
    check_out("drop.grant", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int k = 1; k < MH; k++) begin
      step(8'h04, 1'b0);
      check_out($sformatf("drop.hold%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step(8'h00, 1'b1);
    check_out("drop.release", 8'h00, 3'd0, 1'b0, 1'b0);
    step(8'hFF, 1'b0);
    check_out("drop.next", 8'h08, 3'd3, 1'b1, 1'b0);

    // Random traffic against the reference model.
    do_reset(8'h00);
    cur_req = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       cur_req = 8'($urandom);
          1:       cur_req = 8'($urandom) & 8'($urandom) & 8'($urandom);
          2:       cur_req = 8'h01 << $urandom_range(0, 7);
          default: cur_req = 8'h00;
        endcase
      end
      cur_rel = ($urandom_range(0, 7) == 0);
      step(cur_req, cur_rel);
      model_edge(cur_req, cur_rel);
      check_out($sformatf("rnd%0d", c),
                (m_owner < 0) ? 8'h00 : 8'h01 << m_owner,
                (m_owner < 0) ? 3'd0 : 3'(m_owner),
                (m_owner >= 0), m_to[0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
